// File: rtl/regfile_dump_ctrl_if.sv
// regfile_dump_ctrl_if
//   Beat stream carrying architectural register values out of the dump
//   sequencer.
//
//   Handshake: a beat transfers on a rising clock edge where dump_valid and
//   dump_ready are both high. Once dump_valid is raised, dump_idx, dump_data
//   and dump_last stay stable and dump_valid stays high until that transfer.
//   dump_ready may change freely and never depends combinationally on
//   dump_valid.
//
//   Signals:
//     dump_valid  master -> slave  a beat is present
//     dump_ready  slave  -> master consumer accepts the beat
//     dump_idx    master -> slave  register index of the beat (5 bits)
//     dump_data   master -> slave  register value (32 bits)
//     dump_last   master -> slave  final beat of the sequence
interface regfile_dump_ctrl_if;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        dump_last;

  modport master (
    output dump_valid,
    input  dump_ready,
    output dump_idx,
    output dump_data,
    output dump_last
  );

  modport slave (
    input  dump_valid,
    output dump_ready,
    input  dump_idx,
    input  dump_data,
    input  dump_last
  );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl
//   Runs the processor for a programmed number of cycles, then freezes it and
//   takes over regfile read port A to stream registers 0..NUM_REGS-1 out over
//   the dump interface.
//
//   Optional feature macro: REGFILE_DUMP_CHECKSUM_EN
//     When defined, an XOR checksum of all dumped values is sent as one extra
//     beat (idx 31, dump_last=1) after the final register.
//
//   Ports:
//     clock, reset   rising-edge clock, synchronous active-high reset
//     start          begin a run/dump sequence (sampled only in IDLE)
//     run_cycles     processor run length, latched on start
//     cpu_rs1        processor ctrl_readRegA
//     reg_data       regfile data_readRegA (combinational from rs1_out)
//     rs1_out        regfile ctrl_readRegA (dump index while in test mode)
//     test_mode      high in SETTLE, DUMP, CHK and DONE
//     cpu_hold       copy of test_mode, gates processor writes and PC
//     busy           high outside IDLE
//     done           one-cycle pulse after the final beat is accepted
//     state_dbg      current FSM state encoding
//     dump           beat stream (master side)
module regfile_dump_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int CYCLE_W  = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [CYCLE_W-1:0] run_cycles,
  input  logic [4:0]         cpu_rs1,
  input  logic [31:0]        reg_data,
  output logic [4:0]         rs1_out,
  output logic               test_mode,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state_dbg,
  regfile_dump_ctrl_if.master dump
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_SETTLE = 3'd2,
    S_DUMP   = 3'd3,
`ifdef REGFILE_DUMP_CHECKSUM_EN
    S_CHK    = 3'd4,
`endif
    S_DONE   = 3'd5
  } state_t;

  state_t             state;
  logic [CYCLE_W-1:0] cnt;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [31:0]        chk;
`endif

  assign rs1_out   = test_mode ? dump.dump_idx : cpu_rs1;
  assign cpu_hold  = test_mode;
  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      dump.dump_idx   <= '0;
      dump.dump_data  <= '0;
      dump.dump_valid <= 1'b0;
      dump.dump_last  <= 1'b0;
      test_mode       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      chk             <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt           <= run_cycles;
            dump.dump_idx <= '0;
            busy          <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            chk           <= '0;
`endif
            // A zero run length skips RUN and freezes the CPU immediately.
            if (run_cycles != '0) begin
              state <= S_RUN;
            end else begin
              state     <= S_SETTLE;
              test_mode <= 1'b1;
            end
          end
        end

        S_RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CYCLE_W'(1)) begin
            state     <= S_SETTLE;
            test_mode <= 1'b1;
          end
        end

        S_SETTLE: begin
          // rs1_out has pointed at dump_idx for this whole cycle, so the
          // regfile read has settled by this edge.
          dump.dump_data  <= reg_data;
          dump.dump_valid <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          dump.dump_last  <= 1'b0;
`else
          dump.dump_last  <= (dump.dump_idx == LAST_IDX);
`endif
          state           <= S_DUMP;
        end

        S_DUMP: begin
          if (dump.dump_ready) begin
            if (dump.dump_idx == LAST_IDX) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              // Fold the final value in while loading the checksum beat.
              chk             <= chk ^ dump.dump_data;
              dump.dump_data  <= chk ^ dump.dump_data;
              dump.dump_idx   <= 5'd31;
              dump.dump_last  <= 1'b1;
              state           <= S_CHK;
`else
              dump.dump_valid <= 1'b0;
              dump.dump_last  <= 1'b0;
              done            <= 1'b1;
              state           <= S_DONE;
`endif
            end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              chk             <= chk ^ dump.dump_data;
`endif
              dump.dump_valid <= 1'b0;
              dump.dump_idx   <= dump.dump_idx + 5'd1;
              state           <= S_SETTLE;
            end
          end
        end

`ifdef REGFILE_DUMP_CHECKSUM_EN
        S_CHK: begin
          if (dump.dump_ready) begin
            dump.dump_valid <= 1'b0;
            dump.dump_last  <= 1'b0;
            done            <= 1'b1;
            state           <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          done      <= 1'b0;
          test_mode <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
module tb_regfile_dump_ctrl;
  localparam int NUM_REGS = 32;
  localparam int CYCLE_W  = 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic               start;
  logic [CYCLE_W-1:0] run_cycles;
  logic [4:0]         cpu_rs1;
  logic [31:0]        reg_data;
  logic [4:0]         rs1_out;
  logic               test_mode, cpu_hold, busy, done;
  logic [2:0]         state_dbg;

  regfile_dump_ctrl_if dif ();

  regfile_dump_ctrl #(.NUM_REGS(NUM_REGS), .CYCLE_W(CYCLE_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .run_cycles (run_cycles),
    .cpu_rs1    (cpu_rs1),
    .reg_data   (reg_data),
    .rs1_out    (rs1_out),
    .test_mode  (test_mode),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg),
    .dump       (dif.master)
  );

  // Regfile model: combinational read port A.
  logic [31:0] regs [32];
  assign reg_data = regs[rs1_out];

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
    logic        is_chk;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] cap_data [32];
  logic [31:0] cap_chk_data;
  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int done_exp = 0;
  int ready_mode = 0;
  int rdy_phase = 0;
  logic  prev_stall = 1'b0;
  beat_t prev_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beat list for one full sequence, built from the register image.
  task automatic push_expected();
    beat_t b;
    logic [31:0] x;
    x = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      b.idx    = 5'(i);
      b.data   = regs[i];
      b.is_chk = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      b.last   = 1'b0;
`else
      b.last   = (i == NUM_REGS - 1);
`endif
      x = x ^ regs[i];
      exp_q.push_back(b);
    end
`ifdef REGFILE_DUMP_CHECKSUM_EN
    b.idx = 5'd31; b.data = x; b.last = 1'b1; b.is_chk = 1'b1;
    exp_q.push_back(b);
`endif
  endtask

  // ---------------- drivers: ready and cpu_rs1, changed just after posedge ----------------
  always @(posedge clock) begin
    #1;
    cpu_rs1 = 5'($urandom_range(0, 31));
    case (ready_mode)
      0: dif.dump_ready = 1'b1;
      1: dif.dump_ready = 1'($urandom_range(0, 1));
      default: begin
        dif.dump_ready = (rdy_phase == 0);
        rdy_phase = (rdy_phase + 1) % 4;
      end
    endcase
  end

  // ---------------- compare process (samples on negedge) ----------------
  always @(negedge clock) begin
    beat_t cur, b;
    cur.idx = dif.dump_idx; cur.data = dif.dump_data; cur.last = dif.dump_last; cur.is_chk = 1'b0;
    if (reset !== 1'b0) begin
      prev_stall = 1'b0;
    end else begin
      chk("cpu_hold_eq_test_mode", cpu_hold, test_mode);
      if (!test_mode) chk("rs1_passthru", rs1_out, cpu_rs1);
      if (prev_stall) begin
        chk("stall_valid_held", dif.dump_valid, 1'b1);
        chk("stall_beat_held", {cur.idx, cur.data, cur.last}, {prev_b.idx, prev_b.data, prev_b.last});
      end
      if (dif.dump_valid && dif.dump_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat actual_idx=%0d required=no_beat at %0t", dif.dump_idx, $time);
        end else begin
          b = exp_q.pop_front();
          chk("beat_idx", dif.dump_idx, b.idx);
          chk("beat_data", dif.dump_data, b.data);
          chk("beat_last", dif.dump_last, b.last);
          if (b.is_chk) cap_chk_data = dif.dump_data;
          else cap_data[b.idx] = dif.dump_data;
        end
      end
      prev_stall = dif.dump_valid && !dif.dump_ready;
      prev_b = cur;
      if (done) done_seen++;
    end
  end

  // ---------------- sequence driver (called at a negedge) ----------------
  task automatic run_seq(input int rc, input bit inject, input int exp_lat);
    int hold;
    int lat;
    push_expected();
    done_exp++;
    run_cycles = CYCLE_W'(rc);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_rise", busy, 1'b1);
    hold = 0;
    while (cpu_hold !== 1'b1 && hold < 1000) begin
      hold++;
      start = inject && (hold == 2) && (rc >= 2);
      @(negedge clock);
    end
    start = 1'b0;
    chk("run_window", hold, rc);
    lat = 1;
    while (done !== 1'b1 && lat < 5000) begin
      @(negedge clock);
      lat++;
      start = inject && dif.dump_valid && (dif.dump_idx == 5'd3);
    end
    start = 1'b0;
    chk("done_seen", done, 1'b1);
    if (exp_lat > 0) chk("done_latency", lat, exp_lat);
    @(negedge clock);
    chk("idle_busy", busy, 1'b0);
    chk("idle_test_mode", test_mode, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("exp_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_values();
    chk("rst_test_mode", test_mode, 1'b0);
    chk("rst_cpu_hold", cpu_hold, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", dif.dump_valid, 1'b0);
    chk("rst_last", dif.dump_last, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_idx", dif.dump_idx, 5'd0);
    chk("rst_data", dif.dump_data, 32'd0);
    chk("rst_rs1", rs1_out, cpu_rs1);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int n;
    int full_lat;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    full_lat = 2 * NUM_REGS + 2;
`else
    full_lat = 2 * NUM_REGS + 1;
`endif
    reset = 1'b1;
    start = 1'b0;
    run_cycles = '0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);
    repeat (3) @(negedge clock);
    check_reset_values();
    reset = 1'b0;
    @(negedge clock);

    // Basic run: 5 cycles, ready tied high, r_i = 3*i.
    ready_mode = 0;
    run_seq(5, 1'b0, full_lat);
    chk("lit_r10", cap_data[10], 32'd30);
    chk("lit_r31", cap_data[31], 32'd93);
    chk("lit_r1", cap_data[1], 32'd3);

    // Zero run length: straight to SETTLE.
    run_seq(0, 1'b0, full_lat);

    // Back-pressure: 1 cycle on / 3 off, random register image.
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    ready_mode = 2;
    run_seq($urandom_range(1, 9), 1'b0, 0);

    // Stray start pulses during RUN and DUMP must be ignored.
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    ready_mode = 1;
    run_seq(6, 1'b1, 0);

    // Reset mid-dump at index 12, then a clean restart.
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    push_expected();
    run_cycles = CYCLE_W'(3);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!(dif.dump_valid === 1'b1 && dif.dump_idx == 5'd12) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk("reach_idx12", dif.dump_idx, 5'd12);
    reset = 1'b1;
    @(negedge clock);
    check_reset_values();
    prev_stall = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    run_seq($urandom_range(0, 4), 1'b0, 0);

    // Random runs.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      ready_mode = $urandom_range(0, 2);
      run_seq($urandom_range(0, 12), 1'b0, 0);
    end

    // One-hot image: checksum beat (if present) must be all ones.
    for (int i = 0; i < 32; i++) regs[i] = 32'h1 << i;
    ready_mode = 0;
    run_seq(2, 1'b0, full_lat);
    chk("lit_onehot_r31", cap_data[31], 32'h8000_0000);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    chk("lit_checksum", cap_chk_data, 32'hFFFF_FFFF);
`endif

    chk("done_count", done_seen, done_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
